// File: rtl/byte_packer_pkg.sv
// Shared types and constants for the byte packer: word geometry, packer index
// states and the FIFO entry layout.
package byte_packer_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 32;
   localparam int CNT_W          = 3;

   typedef enum logic [1:0] {
      IDX0,
      IDX1,
      IDX2,
      IDX3
   } pack_idx_e;

   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [CNT_W-1:0]  bytes;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/byte_packer_if.sv
// Byte stream in, packed-word stream out, plus the overflow status pair.
// master = packer side, slave = producer/consumer side.
interface byte_packer_if;
   import byte_packer_pkg::*;

   logic [7:0]        data_in;
   logic              data_in_valid;
   logic              flush;
   logic [WORD_W-1:0] word_out;
   logic [CNT_W-1:0]  word_bytes;
   logic              word_valid;
   logic              word_ready;
   logic              overflow;
   logic              overflow_clr;

   modport master (
      input  data_in, data_in_valid, flush, word_ready, overflow_clr,
      output word_out, word_bytes, word_valid, overflow
   );

   modport slave (
      output data_in, data_in_valid, flush, word_ready, overflow_clr,
      input  word_out, word_bytes, word_valid, overflow
   );

endinterface

// File: rtl/byte_packer_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is taken
// only when a pop frees a slot in the same cycle. Head reads as zero when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words and queues them for a
// valid/ready consumer; words that find the queue full are dropped and flagged.
module byte_packer
   import byte_packer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk_b,
   input  logic          rst_n,
   byte_packer_if.master bus
);

   pack_idx_e         state_q;
   pack_idx_e         state_d;
   logic [1:0]        idx;
   logic [23:0]       partial_q;
   logic [23:0]       partial_d;
   logic [WORD_W-1:0] cur_word;
   logic [CNT_W-1:0]  fill_cnt;
   logic              word_done;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              drop;
   logic              overflow_q;
   fifo_entry_t       push_entry;
   fifo_entry_t       head_entry;

   assign idx = state_q;

   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDX0;
         partial_q <= '0;
      end else begin
         state_q   <= state_d;
         partial_q <= partial_d;
      end
   end

   // The incoming byte is merged before the push decision, so a flush in the
   // same cycle carries it, and a byte that completes the word pushes only once.
   always_comb begin
      cur_word = {8'h00, partial_q};
      if (bus.data_in_valid) cur_word[{idx, 3'b000} +: 8] = bus.data_in;
      fill_cnt  = {1'b0, idx} + {2'b00, bus.data_in_valid};
      word_done = (fill_cnt == 3'd4) || (bus.flush && (fill_cnt != 3'd0));
      state_d   = state_q;
      partial_d = partial_q;
      if (word_done) begin
         state_d   = IDX0;
         partial_d = '0;
      end else if (bus.data_in_valid) begin
         state_d   = pack_idx_e'(idx + 2'd1);
         partial_d = cur_word[23:0];
      end
   end

   assign push_entry = '{word: cur_word, bytes: fill_cnt};
   assign pop        = !fifo_empty && bus.word_ready;
   assign drop       = word_done && fifo_full && !pop;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_b),
      .rst_n     (rst_n),
      .push      (word_done),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n)                overflow_q <= 1'b0;
      else if (drop)             overflow_q <= 1'b1;
      else if (bus.overflow_clr) overflow_q <= 1'b0;
   end

   assign bus.word_out   = head_entry.word;
   assign bus.word_bytes = head_entry.bytes;
   assign bus.word_valid = !fifo_empty;
   assign bus.overflow   = overflow_q;

endmodule
